serial_comparator_ctrl: RTL
===========================

# serial_comparator_ctrl

Sequencer that compares two WIDTH-bit unsigned operands one bit per cycle, MSB first, by driving a single instance of the team's 1-bit `comparator` cell. It captures the operands on a start pulse, terminates at the first differing bit pair, and returns a registered one-hot lt/gt/eq result with a one-cycle done pulse. It sits between a requesting control unit and the 1-bit comparator datapath, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- i_w_clk  input  1  clock; all state updates on the rising edge.
- i_w_rst_n  input  1  reset; asynchronous assert, active-low.
- i_w_start  input  1  request pulse; sampled only in IDLE.
- i_w_a  input  WIDTH  operand A; unsigned; captured on an accepted start.
- i_w_b  input  WIDTH  operand B; unsigned; captured on an accepted start.
- o_w_busy  output  1  high in SCAN and DONE.
- o_w_done  output  1  one-cycle pulse in DONE; marks the result as newly valid.
- o_w_lt  output  1  A < B; registered.
- o_w_gt  output  1  A > B; registered.
- o_w_eq  output  1  A == B; registered.

## Operation
- States: IDLE, SCAN, DONE. The encoding is 2 bits: IDLE=0, SCAN=1, DONE=2. Code 3 is illegal and recovers to IDLE.
- IDLE:
  - When i_w_start=1, load shift registers sh_a<=i_w_a and sh_b<=i_w_b.
  - Load the index counter idx<=WIDTH-1.
  - Go to SCAN.
  - Result outputs hold their previous values.
- SCAN:
  - The comparator cell sees sh_a[WIDTH-1] and sh_b[WIDTH-1].
  - If the cell's lt or gt output is 1, register that result with the other two outputs at 0, then go to DONE.
  - Otherwise, if idx==0, register eq=1 with lt=gt=0, then go to DONE.
  - Otherwise, shift both registers left by 1, decrement idx, and stay in SCAN.
- DONE: o_w_done=1 for exactly one cycle, then unconditionally go to IDLE.
- i_w_start is ignored in SCAN and DONE. It is not queued.
- i_w_a and i_w_b changing after capture has no effect on the comparison in progress.
- Counter width is $clog2(WIDTH). idx never wraps: SCAN exits when idx==0.
- After the first completion the result outputs are exactly one-hot. Before that they are all 0.

## Timing
- Reset: state=IDLE. o_w_busy, o_w_done, o_w_lt, o_w_gt and o_w_eq are all 0. sh_a, sh_b and idx are 0.
- Start is accepted at edge E0. SCAN evaluates bit WIDTH-1 in the cycle after E0.
- If the first difference is found at bit position p (MSB=WIDTH-1), the number of bits examined is k = WIDTH-p. For equal operands, k=WIDTH.
- The result registers update at edge Ek. o_w_done is high during the cycle following Ek.
- Latency from the accepting edge to the done cycle is k cycles, with 1 ≤ k ≤ WIDTH.
- o_w_busy rises in the cycle after E0 and falls in the cycle after DONE.
- The earliest next accepted start is at the edge that ends DONE+1, i.e. start sampled in IDLE. Back-to-back throughput is k+2 cycles per comparison.
- Reset asserted mid-SCAN or mid-DONE:
  - Immediately forces the reset values above, without waiting for a clock edge.
  - Discards the comparison in progress.
  - No done pulse is produced.
- Reset released with i_w_start already high: the start is accepted at the first rising edge after release.

## Structure
- Shared header `serial_comparator_defs.vh` holds the state encodings (S_IDLE, S_SCAN, S_DONE) and the max WIDTH constant.
- The only sub-module is one instance of the 1-bit `comparator` cell. Its outputs drive the next-state and result logic combinationally.
- No other sub-modules are used. The FSM, shift registers and counter live in this module.

## Test plan
- Reset state: hold i_w_rst_n=0 with random inputs -> all outputs 0. Release, start with A=0x00, B=0x00 -> done 8 cycles after acceptance with eq=1, lt=0, gt=0.
- MSB decides: A=0x80, B=0x7F -> done 1 cycle after acceptance with gt=1.
- LSB decides: A=0x12, B=0x13 -> done 8 cycles after acceptance with lt=1. Operands toggled during SCAN do not change the result.
- Start during busy:
  - A=0x01, B=0x00 accepted.
  - Second start with A=0x00, B=0xFF issued mid-SCAN is ignored.
  - Only one done pulse, with gt=1.
  - Results hold until the next accepted start.
- Reset mid-SCAN: A=0x0F, B=0x0E, assert i_w_rst_n=0 after 3 SCAN cycles -> outputs 0 immediately and no done pulse. Then a fresh compare of A=0x05, B=0x09 -> done after 5 cycles with lt=1.
- Parameter sweep: WIDTH=2 and WIDTH=32 with random operands against a reference model -> one-hot result matches the model and latency equals WIDTH-p.

Source files
------------

// File: rtl/serial_comparator_ctrl_pkg.sv
// serial_comparator_ctrl_pkg
//   Shared definitions for the bit-serial comparator sequencer: FSM state
//   encoding and the legal operand-width range.
package serial_comparator_ctrl_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Code 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_comparator_ctrl_comparator.sv
// serial_comparator_ctrl_comparator
//   1-bit magnitude comparator cell, purely combinational.
//   a_i, b_i : the bit pair under comparison
//   lt_o     : a_i < b_i
//   gt_o     : a_i > b_i
//   eq_o     : a_i == b_i
module serial_comparator_ctrl_comparator (
  input  logic a_i,
  input  logic b_i,
  output logic lt_o,
  output logic gt_o,
  output logic eq_o
);

  assign lt_o = ~a_i & b_i;
  assign gt_o = a_i & ~b_i;
  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// serial_comparator_ctrl
//   Compares two WIDTH-bit unsigned operands one bit per cycle, MSB first,
//   through a single 1-bit comparator cell. Stops at the first differing bit
//   and registers a one-hot lt/gt/eq result with a one-cycle done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for i_w_start; result outputs hold last value
//   SCAN  | comparing the MSBs of the shift registers, one bit per cycle
//   DONE  | result valid and newly updated; o_w_done high for one cycle
//
//   Ports:
//     i_w_clk    : clock, rising edge
//     i_w_rst_n  : asynchronous active-low reset
//     i_w_start  : request pulse, sampled only in IDLE
//     i_w_a/b    : operands, captured on an accepted start
//     o_w_busy   : high in SCAN and DONE
//     o_w_done   : one-cycle pulse in DONE
//     o_w_lt/gt/eq : registered one-hot result (all 0 until first completion)
module serial_comparator_ctrl
  import serial_comparator_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic             o_w_lt,
  output logic             o_w_gt,
  output logic             o_w_eq
);

  localparam int IDX_W = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_comparator_ctrl: WIDTH out of range");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;

  logic               cmp_lt, cmp_gt, cmp_eq;

  serial_comparator_ctrl_comparator u_cmp (
    .a_i  (sh_a_q[WIDTH-1]),
    .b_i  (sh_b_q[WIDTH-1]),
    .lt_o (cmp_lt),
    .gt_o (cmp_gt),
    .eq_o (cmp_eq)
  );

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;

    case (state_q)
      S_IDLE: begin
        if (i_w_start) begin
          sh_a_d  = i_w_a;
          sh_b_d  = i_w_b;
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (cmp_lt || cmp_gt) begin
          lt_d    = cmp_lt;
          gt_d    = cmp_gt;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (cmp_eq && (idx_q == '0)) begin
          // Last bit pair matched too: operands are equal.
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          sh_a_d  = {sh_a_q[WIDTH-2:0], 1'b0};
          sh_b_d  = {sh_b_q[WIDTH-2:0], 1'b0};
          idx_d   = idx_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= S_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign o_w_busy = (state_q == S_SCAN) || (state_q == S_DONE);
  assign o_w_done = (state_q == S_DONE);
  assign o_w_lt   = lt_q;
  assign o_w_gt   = gt_q;
  assign o_w_eq   = eq_q;

endmodule
